imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/mips_pkg.sv | 28 ++
 rtl/word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// program-stream format constants and the checksum step.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_e;

    localparam int LEN_FIELD_W    = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 2;

    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data_byte);
        return csum ^ data_byte;
    endfunction

    // States in which the loader pulls bytes from the stream.
    function automatic logic is_loading(input loader_state_e st);
        return (st == ST_LEN_HI) || (st == ST_LEN_LO) || (st == ST_DATA) || (st == ST_CHECK);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects big-endian stream bytes into a 32-bit word; flags the byte that
// completes a word.
module word_assembler
    import mips_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [31:0]           r_shift;

    assign o_word      = r_shift;
    assign o_word_done = i_valid && (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    // Shift register and byte position; counter wraps naturally after byte 3.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt <= BYTE_CNT_W'(0);
            r_shift    <= 32'd0;
        end else if (i_clr) begin
            r_byte_cnt <= BYTE_CNT_W'(0);
        end else if (i_valid) begin
            r_shift    <= {r_shift[23:0], i_byte};
            r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed program stream,
// writes it into instruction memory and releases the CPU only on success.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    loader_state_e          r_state;
    loader_state_e          w_next_state;
    logic                   r_byte_ready;
    logic                   r_mem_we;
    logic                   r_cpu_rst;
    logic                   r_done;
    logic                   r_error;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [7:0]             r_len_hi;
    logic [7:0]             r_checksum;
    logic [LEN_FIELD_W-1:0] r_words_left;
    logic                   w_accept;
    logic                   w_start;
    logic                   w_data_valid;
    logic                   w_word_done;
    logic                   w_last_write;
    logic [LEN_FIELD_W-1:0] w_len;
    logic [31:0]            w_word;

    assign w_accept     = byte_valid && r_byte_ready;
    assign w_start      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_len        = {r_len_hi, byte_data};
    assign w_data_valid = w_accept && (r_state == ST_DATA);
    assign w_last_write = r_mem_we && (r_words_left == LEN_FIELD_W'(1));

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = w_word;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign error      = r_error;

    word_assembler u_word_assembler (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_clr       (w_start),
        .i_valid     (w_data_valid),
        .i_byte      (byte_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) w_next_state = ST_LEN_HI;
                else       w_next_state = r_state;
            end
            ST_LEN_HI: begin
                if (w_accept) w_next_state = ST_LEN_LO;
                else          w_next_state = r_state;
            end
            ST_LEN_LO: begin
                if (!w_accept)                          w_next_state = r_state;
                else if (w_len == LEN_FIELD_W'(0))      w_next_state = ST_CHECK;
                else if (32'(w_len) > MAX_WORDS)        w_next_state = ST_ERR;
                else                                    w_next_state = ST_DATA;
            end
            ST_DATA: begin
                if (w_last_write) w_next_state = ST_CHECK;
                else              w_next_state = r_state;
            end
            ST_CHECK: begin
                if (!w_accept)                     w_next_state = r_state;
                else if (byte_data == r_checksum)  w_next_state = ST_DONE;
                else                               w_next_state = ST_ERR;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register and registered control outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_byte_ready <= is_loading(w_next_state) && !w_word_done;
            r_mem_we     <= w_word_done;
            r_cpu_rst    <= (w_next_state != ST_DONE);
            r_done       <= (w_next_state == ST_DONE);
            r_error      <= (w_next_state == ST_ERR);
        end
    end

    // Length capture, word address, remaining-word count and running checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr   <= ADDR_W'(0);
            r_len_hi     <= 8'd0;
            r_checksum   <= 8'd0;
            r_words_left <= LEN_FIELD_W'(0);
        end else if (w_start) begin
            r_mem_addr   <= ADDR_W'(0);
            r_len_hi     <= 8'd0;
            r_checksum   <= 8'd0;
            r_words_left <= LEN_FIELD_W'(0);
        end else begin
            if (w_accept && (r_state == ST_LEN_HI)) r_len_hi <= byte_data;
            if (w_accept && (r_state == ST_LEN_LO)) r_words_left <= w_len;
            if (w_data_valid) r_checksum <= csum_next(r_checksum, byte_data);
            // Address holds on the final write so it never wraps at full depth.
            if (r_mem_we) begin
                r_words_left <= r_words_left - LEN_FIELD_W'(1);
                if (!w_last_write) r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as words are sent,
// observed writes collected each cycle and compared per scenario.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    int vectors;
    int miscompares;

    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] obs_q[$];
    logic [31:0]        words [0:3];
    logic               both_flags_seen;
    logic               we_ready_clash;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and record any memory write seen there.
    task automatic step();
        @(negedge clk);
        if (mem_we) begin
            obs_q.push_back({mem_addr, mem_wdata});
            if (byte_ready) we_ready_clash = 1'b1;
        end
        if (done && error) both_flags_seen = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) step();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        guard      = 0;
        while (!byte_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!byte_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake: byte_ready stayed 0 while sending %02h", b);
        end
        step();
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Sends a full stream of n words from words[]; the checksum byte is XORed with csum_mask.
    task automatic run_stream(input logic [15:0] n, input bit gaps, input logic [7:0] csum_mask);
        logic [7:0] cs;
        int g;
        cs = 8'd0;
        do_start();
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        for (int w = 0; w < int'(n); w++) begin
            exp_q.push_back({ADDR_W'(w), words[w]});
            for (int k = 3; k >= 0; k--) begin
                send_byte(words[w][8*k +: 8], gaps);
                cs = cs ^ words[w][8*k +: 8];
            end
        end
        send_byte(cs ^ csum_mask, gaps);
        g = 0;
        while (!(done || error) && g < 50) begin
            step();
            g++;
        end
    endtask

    task automatic test_reset();
        logic [ADDR_W+36:0] got;
        rst        = 1'b0;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        repeat (3) step();
        got = {byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error};
        vectors++;
        if (got !== {1'b0, 1'b0, ADDR_W'(0), 32'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want ready0 we0 addr0 wdata0 cpu_rst1 done0 error0", got);
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        rst        = 1'b1;
        step();
        step();
        vectors++;
        if ({byte_ready, cpu_rst, done, error} !== 4'b0100) begin
            miscompares++;
            $display("FAIL idle_after_reset: ready/cpu_rst/done/error = %b want 0100", {byte_ready, cpu_rst, done, error});
        end
        obs_q.delete();
    endtask

    task automatic test_single_word();
        logic [ADDR_W+31:0] e, o;
        words[0] = 32'h12345678;
        run_stream(16'd1, 1'b0, 8'h00);
        vectors++;
        if ({done, error, cpu_rst, byte_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL single_done: done/error/cpu_rst/ready = %b want 1000", {done, error, cpu_rst, byte_ready});
        end
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL single_count: %0d writes, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL single_write: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        // Checksum byte 0x70 is wrong for this word (XOR is 0x08).
        run_stream(16'd1, 1'b0, 8'h78);
        vectors++;
        if ({done, error, cpu_rst} !== 3'b011 || obs_q.size() !== 1) begin
            miscompares++;
            $display("FAIL single_badsum: done/error/cpu_rst = %b writes %0d want 011 writes 1", {done, error, cpu_rst}, obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_two_words();
        logic [ADDR_W+31:0] e, o;
        words[0] = 32'h20080005;
        words[1] = 32'h01094020;
        run_stream(16'd2, 1'b0, 8'h00);
        vectors++;
        if ({done, error, cpu_rst} !== 3'b100) begin
            miscompares++;
            $display("FAIL two_done: done/error/cpu_rst = %b want 100", {done, error, cpu_rst});
        end
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL two_count: %0d writes, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL two_write: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_zero_len();
        run_stream(16'd0, 1'b0, 8'h00);
        vectors++;
        if ({done, error, cpu_rst} !== 3'b100 || obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL zero_ok: done/error/cpu_rst = %b writes %0d want 100 writes 0", {done, error, cpu_rst}, obs_q.size());
        end
        run_stream(16'd0, 1'b0, 8'hFF);
        vectors++;
        if ({done, error, cpu_rst} !== 3'b011 || obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL zero_badsum: done/error/cpu_rst = %b writes %0d want 011 writes 0", {done, error, cpu_rst}, obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bad_len();
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        vectors++;
        if ({byte_ready, error} !== 2'b10) begin
            miscompares++;
            $display("FAIL len_max_ok: ready/error = %b want 10", {byte_ready, error});
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        step();
        vectors++;
        if ({error, done, byte_ready, cpu_rst} !== 4'b1001 || obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL len_too_big: error/done/ready/cpu_rst = %b writes %0d want 1001 writes 0", {error, done, byte_ready, cpu_rst}, obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random_valid();
        logic [ADDR_W+31:0] e, o;
        logic [ADDR_W+31:0] ref_q[$];
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        run_stream(16'd3, 1'b0, 8'h00);
        ref_q = exp_q;
        exp_q.delete(); obs_q.delete();
        run_stream(16'd3, 1'b1, 8'h00);
        vectors++;
        if ({done, error} !== 2'b10 || obs_q.size() !== ref_q.size()) begin
            miscompares++;
            $display("FAIL gaps_outcome: done/error = %b writes %0d want 10 writes %0d", {done, error}, obs_q.size(), ref_q.size());
        end
        while (ref_q.size() > 0 && obs_q.size() > 0) begin
            e = ref_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL gaps_write: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_mid_reset();
        logic [ADDR_W+36:0] got;
        logic [ADDR_W+31:0] e, o;
        words[0] = 32'hCAFE0001;
        words[1] = 32'hBEEF0002;
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int k = 3; k >= 0; k--) send_byte(words[0][8*k +: 8], 1'b0);
        send_byte(words[1][31:24], 1'b0);
        send_byte(words[1][23:16], 1'b0);
        rst = 1'b0;
        #1;
        got = {byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error};
        vectors++;
        if (got !== {1'b0, 1'b0, ADDR_W'(0), 32'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %h want ready0 we0 addr0 wdata0 cpu_rst1 done0 error0", got);
        end
        repeat (4) step();
        rst = 1'b1;
        step();
        vectors++;
        if (obs_q.size() !== 1 || obs_q[0] !== {ADDR_W'(0), words[0]}) begin
            miscompares++;
            $display("FAIL midrst_partial: %0d writes (first %h) want 1 write %h", obs_q.size(), obs_q[0], {ADDR_W'(0), words[0]});
        end
        exp_q.delete(); obs_q.delete();
        run_stream(16'd2, 1'b0, 8'h00);
        vectors++;
        if ({done, error, cpu_rst} !== 3'b100 || obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL midrst_reload: done/error/cpu_rst = %b writes %0d want 100 writes %0d", {done, error, cpu_rst}, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL midrst_write: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        both_flags_seen = 1'b0;
        we_ready_clash  = 1'b0;
        start           = 1'b0;
        byte_valid      = 1'b0;
        byte_data       = 8'h00;
        rst             = 1'b0;
        test_reset();
        test_single_word();
        test_two_words();
        test_zero_len();
        test_bad_len();
        test_random_valid();
        test_mid_reset();
        vectors++;
        if (both_flags_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL flags_exclusive: done and error seen together (%b) want 0", both_flags_seen);
        end
        vectors++;
        if (we_ready_clash !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_in_write: byte_ready high during mem_we (%b) want 0", we_ready_clash);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
